// File: rtl/component_slice_scheduler.sv
// Sequences one ProRes slice through the component pipeline as Y, Cb, Cr runs,
// gating the pipeline reset and collecting per-component and per-slice bit counts.
module component_slice_scheduler #(
    parameter int TAIL_CYCLES = 63,
    parameter int GAP_CYCLES  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mb_num,
    input  logic [31:0] comp_bits,
    output logic        busy,
    output logic        comp_reset_n,
    output logic [1:0]  component_id,
    output logic [31:0] block_num,
    output logic        size_valid,
    output logic [31:0] size_bits,
    output logic [31:0] slice_bits,
    output logic        slice_done,
    output logic        start_error
);

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        RUN,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

    // Last RUN count for a component: 64 cycles per block plus the flush tail.
    function automatic logic [31:0] run_last(input logic [31:0] blocks);
        return (blocks << 6) + 32'(TAIL_CYCLES) - 32'd1;
    endfunction

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [3:0]  mb_lat, mb_lat_n;
    logic [1:0]  component_id_n;
    logic [31:0] block_num_n;
    logic [31:0] size_bits_n;
    logic [31:0] slice_bits_n;
    logic        start_error_n;
    logic        mb_ok;

    assign mb_ok = (mb_num >= 4'd1) && (mb_num <= 4'd8);

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        mb_lat_n       = mb_lat;
        component_id_n = component_id;
        block_num_n    = block_num;
        size_bits_n    = size_bits;
        slice_bits_n   = slice_bits;
        start_error_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (mb_ok) begin
                        mb_lat_n       = mb_num;
                        slice_bits_n   = 32'd0;
                        component_id_n = 2'd0;
                        block_num_n    = {26'd0, mb_num, 2'b00};
                        cnt_n          = 32'd0;
                        state_n        = GAP;
                    end else begin
                        start_error_n = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = 32'd0;
                    state_n = RUN;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            RUN: begin
                if (cnt == run_last(block_num)) begin
                    size_bits_n  = comp_bits;
                    slice_bits_n = slice_bits + comp_bits;
                    cnt_n        = 32'd0;
                    state_n      = CAPTURE;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            CAPTURE: begin
                if (component_id < 2'd2) begin
                    component_id_n = component_id + 2'd1;
                    block_num_n    = {27'd0, mb_lat, 1'b0};
                    state_n        = GAP;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Any start outside IDLE is dropped without touching progress.
        if (start && (state != IDLE)) begin
            start_error_n = 1'b1;
        end
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 32'd0;
            mb_lat       <= 4'd0;
            busy         <= 1'b0;
            comp_reset_n <= 1'b0;
            component_id <= 2'd0;
            block_num    <= 32'd0;
            size_valid   <= 1'b0;
            size_bits    <= 32'd0;
            slice_bits   <= 32'd0;
            slice_done   <= 1'b0;
            start_error  <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            mb_lat       <= mb_lat_n;
            busy         <= (state_n != IDLE);
            comp_reset_n <= (state_n == RUN) || (state_n == CAPTURE);
            component_id <= component_id_n;
            block_num    <= block_num_n;
            size_valid   <= (state_n == CAPTURE);
            size_bits    <= size_bits_n;
            slice_bits   <= slice_bits_n;
            slice_done   <= (state_n == DONE);
            start_error  <= start_error_n;
        end
    end

endmodule

// File: tb/tb_component_slice_scheduler.sv
// Scoreboard bench for component_slice_scheduler: a slice-level timing model
// predicts per-cycle status plus size/done/error events checked by a monitor.
module tb_component_slice_scheduler;

    localparam int GAP  = 2;
    localparam int TAIL = 63;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mb_num = 4'd0;
    logic [31:0] comp_bits = 32'd0;
    logic        busy, comp_reset_n, size_valid, slice_done, start_error;
    logic [1:0]  component_id;
    logic [31:0] block_num, size_bits, slice_bits;

    component_slice_scheduler #(.TAIL_CYCLES(TAIL), .GAP_CYCLES(GAP)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .mb_num      (mb_num),
        .comp_bits   (comp_bits),
        .busy        (busy),
        .comp_reset_n(comp_reset_n),
        .component_id(component_id),
        .block_num   (block_num),
        .size_valid  (size_valid),
        .size_bits   (size_bits),
        .slice_bits  (slice_bits),
        .slice_done  (slice_done),
        .start_error (start_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;   // 0 = size_valid, 1 = slice_done
        int          cyc;
        logic [31:0] val;
    } ev_t;
    typedef struct {
        int          cyc;
        logic [31:0] val;
    } drv_t;

    ev_t  ev_q[$];
    int   err_q[$];
    drv_t drv_q[$];

    bit act = 1'b0;
    int act_s = 0;
    int act_done = 0;
    int act_mb = 0;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, a, e);
        end
    endtask

    function automatic int blocks_of(input int mb, input int k);
        return (k == 0) ? 4 * mb : 2 * mb;
    endfunction

    // Cycles one component occupies: reset gap, run, capture.
    function automatic int comp_len(input int mb, input int k);
        return GAP + 64 * blocks_of(mb, k) + TAIL + 1;
    endfunction

    function automatic void model(input int c, output bit b, output bit crn,
                                  output int cid, output int bn);
        int t;
        b = 1'b0; crn = 1'b0; cid = 0; bn = 0;
        if (!act || c <= act_s || c > act_done) return;
        b = 1'b1;
        t = c - act_s - 1;
        for (int k = 0; k < 3; k++) begin
            int len;
            len = comp_len(act_mb, k);
            if (t < len) begin
                cid = k;
                bn  = blocks_of(act_mb, k);
                crn = (t >= GAP);
                return;
            end
            t -= len;
        end
        cid = 2;
        bn  = blocks_of(act_mb, 2);
        crn = 1'b0;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_comp_reset_n"}, {31'd0, comp_reset_n}, 32'd0);
        chk({tag, "_busy"},         {31'd0, busy},         32'd0);
        chk({tag, "_size_valid"},   {31'd0, size_valid},   32'd0);
        chk({tag, "_slice_done"},   {31'd0, slice_done},   32'd0);
        chk({tag, "_start_error"},  {31'd0, start_error},  32'd0);
        chk({tag, "_component_id"}, {30'd0, component_id}, 32'd0);
        chk({tag, "_block_num"},    block_num,             32'd0);
        chk({tag, "_size_bits"},    size_bits,             32'd0);
        chk({tag, "_slice_bits"},   slice_bits,            32'd0);
    endtask

    task automatic issue_start(input int mb, input logic [31:0] b0,
                               input logic [31:0] b1, input logic [31:0] b2);
        int          c;
        int          t;
        int          cap;
        logic [31:0] bits[3];
        logic [31:0] sum;
        c = cyc;
        bits[0] = b0; bits[1] = b1; bits[2] = b2;
        start  = 1'b1;
        mb_num = 4'(mb);
        if ((act && c <= act_done) || mb < 1 || mb > 8) begin
            err_q.push_back(c + 1);
        end else begin
            act = 1'b1; act_s = c; act_mb = mb;
            sum = 32'd0;
            t = c + 1;
            for (int k = 0; k < 3; k++) begin
                cap = t + comp_len(mb, k) - 1;
                drv_q.push_back('{cap - 1, bits[k]});
                ev_q.push_back('{0, cap, bits[k]});
                sum = sum + bits[k];
                t = cap + 1;
            end
            ev_q.push_back('{1, t, sum});
            act_done = t;
        end
        @(negedge clock);
        start  = 1'b0;
        mb_num = 4'($urandom);
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    // comp_bits holds the scheduled value only in the final RUN cycle.
    always @(negedge clock) begin
        if (drv_q.size() > 0 && drv_q[0].cyc == cyc) begin
            comp_bits = drv_q[0].val;
            void'(drv_q.pop_front());
        end else begin
            comp_bits = $urandom;
        end
    end

    always @(negedge clock) begin : monitor
        bit eb, ecrn;
        int ecid, ebn;
        model(cyc, eb, ecrn, ecid, ebn);
        chk("busy", {31'd0, busy}, {31'd0, eb});
        chk("comp_reset_n", {31'd0, comp_reset_n}, {31'd0, ecrn});
        if (eb) begin
            chk("component_id", {30'd0, component_id}, 32'(ecid));
            chk("block_num", block_num, 32'(ebn));
        end
        if (act && cyc == act_s + 1) chk("slice_bits_clear", slice_bits, 32'd0);

        while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missed_event kind=%0d: pulse absent, required at cycle %0d (now %0d)",
                     ev_q[0].kind, ev_q[0].cyc, cyc);
            void'(ev_q.pop_front());
        end
        if (size_valid) begin
            if (ev_q.size() > 0 && ev_q[0].kind == 0 && ev_q[0].cyc == cyc) begin
                chk("size_bits", size_bits, ev_q[0].val);
                void'(ev_q.pop_front());
            end else begin
                checks++; errors++;
                $display("FAIL unexpected_size_valid at cycle %0d: got 1 required 0", cyc);
            end
        end
        if (slice_done) begin
            if (ev_q.size() > 0 && ev_q[0].kind == 1 && ev_q[0].cyc == cyc) begin
                chk("slice_bits_final", slice_bits, ev_q[0].val);
                void'(ev_q.pop_front());
            end else begin
                checks++; errors++;
                $display("FAIL unexpected_slice_done at cycle %0d: got 1 required 0", cyc);
            end
        end

        while (err_q.size() > 0 && err_q[0] < cyc) begin
            checks++; errors++;
            $display("FAIL missed_start_error: pulse absent, required at cycle %0d", err_q[0]);
            void'(err_q.pop_front());
        end
        if (start_error) begin
            if (err_q.size() > 0 && err_q[0] == cyc) begin
                checks++;
                void'(err_q.pop_front());
            end else begin
                checks++; errors++;
                $display("FAIL unexpected_start_error at cycle %0d: got 1 required 0", cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        #1;
        check_reset("por");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Nominal slice with rejected starts in GAP, RUN and DONE.
        s = cyc;
        issue_start(1, 32'd100, 32'd40, 32'd30);
        issue_start(5, 32'd1, 32'd2, 32'd3);
        goto_cyc(s + 10);
        issue_start(3, 32'd1, 32'd2, 32'd3);
        goto_cyc(s + 711);
        issue_start(2, 32'd1, 32'd2, 32'd3);

        // Accepted in the cycle after slice_done; sum wraps.
        issue_start(1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
        goto_cyc(act_done + 1);
        issue_start(8, $urandom, $urandom, $urandom);
        goto_cyc(act_done + 1);

        // Illegal slice widths while idle.
        issue_start(0, 32'd5, 32'd5, 32'd5);
        issue_start(9, 32'd5, 32'd5, 32'd5);
        issue_start(15, 32'd5, 32'd5, 32'd5);
        repeat (3) @(negedge clock);

        for (int i = 0; i < 3; i++) begin
            issue_start(int'($urandom_range(1, 8)), $urandom, $urandom, $urandom);
            goto_cyc(act_done + 1 + int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of the Cb run.
        issue_start(3, $urandom, $urandom, $urandom);
        s = act_s;
        goto_cyc(s + 1 + comp_len(3, 0) + GAP + 20);
        #2;
        reset = 1'b1;
        act = 1'b0;
        ev_q.delete();
        err_q.delete();
        drv_q.delete();
        #1;
        check_reset("midrun");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        issue_start(2, $urandom, $urandom, $urandom);
        goto_cyc(act_done + 5);

        chk("pending_events", 32'(ev_q.size()), 32'd0);
        chk("pending_errors", 32'(err_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
